spi_burst_master: RTL and testbench
===================================

SPI_BURST_MASTER -- requirements
Module: spi_burst_master

Interface
REQ-001 SHALL have parameter DATA_BIT, default 8: data field width in bits.
REQ-002 SHALL have parameter ADDR_BIT, default 7: address field width in bits.
REQ-003 SHALL have parameter CS_BIT, default 1: chip-select index width; NUM_CS = 2**CS_BIT slaves.
REQ-004 SHALL have parameter CLK_DIV, default 4: SCLK half-period in CLK cycles, legal range 1 or more.
REQ-005 SHALL have port CLK  input  1  system clock; all logic rising-edge.
REQ-006 SHALL have port RSTN  input  1  reset; one clock; reset is synchronous and active-low.
REQ-007 SHALL have port CMD  input  2  command: 00 idle, 01 read, 10 write, 11 reserved.
REQ-008 SHALL have port MODE  input  2  {CPOL, CPHA} for the frame.
REQ-009 SHALL have port CS_SEL  input  CS_BIT  target slave index.
REQ-010 SHALL have port RAM_ADDR  input  ADDR_BIT  slave address.
REQ-011 SHALL have port WR_DATA  input  DATA_BIT  write payload.
REQ-012 SHALL have port MISO  input  1  serial data from slave.
REQ-013 SHALL have port CSN  output  NUM_CS  active-low chip selects.
REQ-014 SHALL have port SCLK  output  1  serial clock.
REQ-015 SHALL have port MOSI  output  1  serial data to slave.
REQ-016 SHALL have port RD_DATA  output  DATA_BIT  last read result.
REQ-017 SHALL have port BUSY  output  1  frame in progress.
REQ-018 SHALL have ports WR_DONE, RD_DONE  output  1 each  one-cycle completion pulses.

Function
REQ-019 SHALL accept a command only in IDLE when CMD is 01 or 10; acceptance edge = T; CMD, MODE, CS_SEL, RAM_ADDR, WR_DATA captured at T.
REQ-020 SHALL ignore CMD 00 and 11 in IDLE, and ignore all CMD values while BUSY.
REQ-021 SHALL use states IDLE -> SETUP (CLK_DIV cycles) -> SHIFT (N bits x 2*CLK_DIV cycles) -> HOLD (CLK_DIV cycles) -> DONE (1 cycle) -> IDLE, N = 1+ADDR_BIT+DATA_BIT.
REQ-022 SHALL drive frame bits MSB first: R/W bit (1 read, 0 write), RAM_ADDR, then data field.
REQ-023 SHALL drive MOSI 0 during the data field of a read, and 0 outside SHIFT.
REQ-024 SHALL register all outputs; CSN[CS_SEL] and BUSY go low/high at T+1; all other CSN bits stay 1.
REQ-025 SHALL hold SCLK = CPOL in IDLE, SETUP, HOLD, DONE.
REQ-026 CPHA=0: each bit SHALL present MOSI for its full period; SCLK = CPOL first half, ~CPOL second half; MISO sampled on the cycle SCLK leaves CPOL.
REQ-027 CPHA=1: SCLK SHALL go ~CPOL at bit start with MOSI updated simultaneously, return to CPOL at half-period; MISO sampled on the cycle SCLK returns to CPOL.
REQ-028 SHALL keep CSN[CS_SEL] low for exactly 2*CLK_DIV*(N+1) cycles, releasing it in the DONE cycle.
REQ-029 SHALL assert WR_DONE (write) or RD_DONE (read) for exactly the DONE cycle; BUSY deasserts the cycle after DONE.
REQ-030 SHALL update RD_DATA only in the DONE cycle of a read, with the DATA_BIT MISO samples of the data field (first sample = MSB); write frames leave it unchanged.
REQ-031 SHALL guarantee CSN high at least 2 cycles between back-to-back frames (CMD held constant re-arms on the first IDLE cycle).
REQ-032 SHALL ignore input changes on MODE, CS_SEL, RAM_ADDR, WR_DATA after T for the rest of the frame.

Reset
REQ-033 With RSTN low at a rising edge: state IDLE, CSN all 1, SCLK 0, MOSI 0, BUSY 0, WR_DONE 0, RD_DONE 0, RD_DATA 0, counters 0.
REQ-034 Reset mid-frame SHALL abort the frame with no DONE pulse; outputs reach reset values on the following cycle; SCLK returns to 0 regardless of captured CPOL.

Verification
REQ-035 Write, defaults with CLK_DIV=2, MODE=00, CS_SEL=1, addr 7'h55, data 8'hA5 -> MOSI 0,1010101,10100101; CSN=2'b01 for 68 cycles; one WR_DONE pulse.
REQ-036 Read, MODE=00, MISO slave returns 8'h3C in the data field -> RD_DONE one pulse, RD_DATA=8'h3C from DONE cycle; MOSI 0 during data field.
REQ-037 MODE=11 write of 8'hFF to addr 0 -> SCLK idles 1, 16 pulses, MOSI changes only when SCLK falls; byte checked by a CPOL=1/CPHA=1 slave model.
REQ-038 CMD=11 in IDLE and CMD toggles while BUSY -> no frame started, CSN unchanged, in-flight frame completes unaltered.
REQ-039 RSTN low during bit 5 of a read with MODE=10 -> next cycle CSN all 1, SCLK 0, BUSY 0, no RD_DONE, RD_DATA keeps reset value 0.
REQ-040 CMD=10 held constant -> back-to-back frames with CSN high exactly 2 cycles between them and one WR_DONE per frame.

Source files
------------

// File: rtl/spi_burst_master.sv
// rtl/spi_burst_master.sv - SPI burst master: one R/W + address + data frame per command
// Outputs are registered from next-state values, so each output reflects the state it appears in.
module spi_burst_master #(
  parameter int DATA_BIT = 8,
  parameter int ADDR_BIT = 7,
  parameter int CS_BIT   = 1,
  parameter int CLK_DIV  = 4
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic [1:0]             CMD,
  input  logic [1:0]             MODE,
  input  logic [CS_BIT-1:0]      CS_SEL,
  input  logic [ADDR_BIT-1:0]    RAM_ADDR,
  input  logic [DATA_BIT-1:0]    WR_DATA,
  input  logic                   MISO,
  output logic [2**CS_BIT-1:0]   CSN,
  output logic                   SCLK,
  output logic                   MOSI,
  output logic [DATA_BIT-1:0]    RD_DATA,
  output logic                   BUSY,
  output logic                   WR_DONE,
  output logic                   RD_DONE
);
  localparam int N      = 1 + ADDR_BIT + DATA_BIT;
  localparam int NUM_CS = 2**CS_BIT;
  localparam int CNT_W  = $clog2(2 * CLK_DIV);
  localparam int BIT_W  = $clog2(N + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HALF      = CNT_W'(CLK_DIV);
  localparam logic [CNT_W-1:0] PER_LAST  = CNT_W'(2 * CLK_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(N - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [N-1:0]        frame_q, frame_d;
  logic [1:0]          mode_q, mode_d;
  logic [CS_BIT-1:0]   sel_q, sel_d;
  logic                rd_q, rd_d;
  logic [DATA_BIT-1:0] rx_q, rx_d;
  logic [NUM_CS-1:0]   csn_q, csn_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic                busy_q, busy_d;
  logic                wr_done_q, wr_done_d;
  logic                rd_done_q, rd_done_d;
  logic [DATA_BIT-1:0] rd_data_q, rd_data_d;
  logic                cmd_rd;

  assign cmd_rd = (CMD == 2'b01);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    frame_d = frame_q;
    mode_d  = mode_q;
    sel_d   = sel_q;
    rd_d    = rd_q;
    rx_d    = rx_q;
    case (state_q)
      S_IDLE: begin
        if (CMD == 2'b01 || CMD == 2'b10) begin
          state_d = S_SETUP;
          cnt_d   = '0;
          bit_d   = '0;
          rd_d    = cmd_rd;
          mode_d  = MODE;
          sel_d   = CS_SEL;
          frame_d = {cmd_rd, RAM_ADDR, cmd_rd ? {DATA_BIT{1'b0}} : WR_DATA};
        end
      end
      S_SETUP: begin
        if (cnt_q == HALF_LAST) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SHIFT: begin
        // Sample at the mid-bit SCLK transition; only the last DATA_BIT samples survive.
        if (cnt_q == HALF) rx_d = {rx_q[DATA_BIT-2:0], MISO};
        if (cnt_q == PER_LAST) begin
          cnt_d = '0;
          if (bit_q == LAST_BIT) begin
            state_d = S_HOLD;
          end else begin
            bit_d   = bit_q + 1'b1;
            frame_d = {frame_q[N-2:0], 1'b0};
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == HALF_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    csn_d = '1;
    if (state_d == S_SETUP || state_d == S_SHIFT || state_d == S_HOLD) csn_d[sel_d] = 1'b0;
    sclk_d = mode_d[1];
    // CPHA flips which half of the bit period SCLK spends away from CPOL.
    if (state_d == S_SHIFT) sclk_d = mode_d[1] ^ mode_d[0] ^ (cnt_d >= HALF);
    mosi_d    = (state_d == S_SHIFT) ? frame_d[N-1] : 1'b0;
    busy_d    = (state_d != S_IDLE);
    wr_done_d = (state_d == S_DONE) && !rd_d;
    rd_done_d = (state_d == S_DONE) && rd_d;
    rd_data_d = ((state_d == S_DONE) && rd_d) ? rx_d : rd_data_q;
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      frame_q   <= '0;
      mode_q    <= '0;
      sel_q     <= '0;
      rd_q      <= 1'b0;
      rx_q      <= '0;
      csn_q     <= '1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      wr_done_q <= 1'b0;
      rd_done_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      frame_q   <= frame_d;
      mode_q    <= mode_d;
      sel_q     <= sel_d;
      rd_q      <= rd_d;
      rx_q      <= rx_d;
      csn_q     <= csn_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      wr_done_q <= wr_done_d;
      rd_done_q <= rd_done_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign CSN     = csn_q;
  assign SCLK    = sclk_q;
  assign MOSI    = mosi_q;
  assign BUSY    = busy_q;
  assign WR_DONE = wr_done_q;
  assign RD_DONE = rd_done_q;
  assign RD_DATA = rd_data_q;
endmodule

// File: tb/tb_spi_burst_master.sv
// tb/tb_spi_burst_master.sv - bench for spi_burst_master: frame-offset model, SPI slave, directed tests
module tb_spi_burst_master;
  localparam int D  = 2;
  localparam int AB = 7;
  localparam int DB = 8;
  localparam int N  = 1 + AB + DB;
  localparam int L  = 2 * D * (N + 1);

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic [1:0] mode = 2'b00;
  logic       cs_sel = 1'b0;
  logic [6:0] ram_addr = '0;
  logic [7:0] wr_data = '0;
  logic       miso = 1'b0;
  logic [1:0] csn;
  logic       sclk, mosi, busy, wr_done, rd_done;
  logic [7:0] rd_data;

  spi_burst_master #(.DATA_BIT(DB), .ADDR_BIT(AB), .CS_BIT(1), .CLK_DIV(D)) dut (
    .CLK(clk), .RSTN(rstn), .CMD(cmd), .MODE(mode), .CS_SEL(cs_sel),
    .RAM_ADDR(ram_addr), .WR_DATA(wr_data), .MISO(miso), .CSN(csn),
    .SCLK(sclk), .MOSI(mosi), .RD_DATA(rd_data), .BUSY(busy),
    .WR_DONE(wr_done), .RD_DONE(rd_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: position of the current cycle inside the frame, counted from the acceptance edge.
  bit         m_valid = 0;
  bit         m_act = 0;
  int         m_o = 0;
  logic [1:0] m_cmd, m_mode;
  logic       m_sel;
  logic [6:0] m_addr;
  logic [7:0] m_wdata, m_resp;
  logic       m_cpol = 1'b0;
  logic [7:0] m_rd = '0;
  logic [7:0] s_resp = '0;

  function automatic logic frame_bit(input int b);
    if (b == 0) return (m_cmd == 2'b01);
    if (b <= AB) return m_addr[AB-b];
    if (m_cmd == 2'b01) return 1'b0;
    return m_wdata[DB-1-(b-1-AB)];
  endfunction

  initial forever begin
    @(posedge clk);
    if (!rstn) begin
      m_valid = 1; m_act = 0; m_cpol = 1'b0; m_rd = '0;
    end else if (m_act) begin
      m_o++;
      if (m_o == L + 1 && m_cmd == 2'b01) m_rd = m_resp;
      if (m_o > L + 1) m_act = 0;
    end else if (cmd == 2'b01 || cmd == 2'b10) begin
      m_act = 1; m_o = 1; m_cmd = cmd; m_mode = mode; m_sel = cs_sel;
      m_addr = ram_addr; m_wdata = wr_data; m_resp = s_resp; m_cpol = mode[1];
    end
  end

  initial forever begin
    logic [1:0] e_csn, one;
    logic e_sclk, e_mosi, e_busy, e_wd, e_rdn, half;
    int s, b, c;
    @(negedge clk);
    if (m_valid) begin
      e_csn = 2'b11; e_sclk = m_cpol; e_mosi = 1'b0; e_busy = 1'b0; e_wd = 1'b0; e_rdn = 1'b0;
      if (m_act) begin
        e_busy = 1'b1;
        one = 2'b01 << m_sel;
        if (m_o <= L) e_csn = ~one;
        s = m_o - D - 1;
        if (s >= 0 && s < 2 * D * N) begin
          b = s / (2 * D);
          c = s % (2 * D);
          half = (c >= D);
          e_sclk = m_mode[0] ? (half ? m_mode[1] : ~m_mode[1]) : (half ? ~m_mode[1] : m_mode[1]);
          e_mosi = frame_bit(b);
        end
        if (m_o == L + 1) begin
          e_wd = (m_cmd == 2'b10);
          e_rdn = (m_cmd == 2'b01);
        end
      end
      check("csn", csn, e_csn);
      check("sclk", sclk, e_sclk);
      check("mosi", mosi, e_mosi);
      check("busy", busy, e_busy);
      check("wr_done", wr_done, e_wd);
      check("rd_done", rd_done, e_rdn);
      check("rd_data", rd_data, m_rd);
    end
  end

  // SPI slave for the configured mode plus per-test statistics.
  logic        s_cpol = 1'b0, s_cpha = 1'b0;
  logic [15:0] s_tx;
  logic [31:0] s_rx = '0, s_last_rx = '0;
  int          s_idx = 0, s_pulses = 0, s_last_pulses = 0, s_mosi_bad = 0;
  logic        s_sel_prev = 1'b0, s_sclk_prev = 1'b0, s_mosi_prev = 1'b0;
  int          csn01_cnt = 0, csn_low_cnt = 0, wd_cnt = 0, rd_cnt = 0, busy_cnt = 0, high_run = 0;
  bit          seen_low = 0;
  int          gaps[$];

  initial forever begin
    logic sel_now, leading;
    @(negedge clk);
    sel_now = (csn != 2'b11);
    if (sel_now && !s_sel_prev) begin
      s_rx = '0; s_pulses = 0; s_idx = 0; s_tx = {8'h00, s_resp};
      if (!s_cpha) begin miso = s_tx[15]; s_idx = 1; end
    end else if (sel_now) begin
      leading = (sclk != s_cpol);
      if (s_cpha && mosi !== s_mosi_prev && s_pulses < N && !(sclk != s_sclk_prev && leading))
        s_mosi_bad++;
      if (sclk != s_sclk_prev) begin
        if (leading) s_pulses++;
        if (leading ^ s_cpha) s_rx = {s_rx[30:0], mosi};
        else begin
          miso = (s_idx < N) ? s_tx[15-s_idx] : 1'b0;
          s_idx++;
        end
      end
    end
    if (!sel_now && s_sel_prev) begin s_last_rx = s_rx; s_last_pulses = s_pulses; end
    if (csn == 2'b01) csn01_cnt++;
    if (csn != 2'b11) csn_low_cnt++;
    if (wr_done) wd_cnt++;
    if (rd_done) rd_cnt++;
    if (busy) busy_cnt++;
    if (csn == 2'b11) high_run++;
    else begin
      if (seen_low && high_run > 0) gaps.push_back(high_run);
      high_run = 0; seen_low = 1;
    end
    s_sel_prev = sel_now; s_sclk_prev = sclk; s_mosi_prev = mosi;
  end

  task automatic setup_test(input logic cpol, input logic cpha, input logic [7:0] resp);
    @(posedge clk);
    s_cpol = cpol; s_cpha = cpha; s_resp = resp;
    csn01_cnt = 0; csn_low_cnt = 0; wd_cnt = 0; rd_cnt = 0; busy_cnt = 0;
    gaps.delete(); seen_low = 0; high_run = 0; s_mosi_bad = 0;
  endtask

  task automatic start_frame(input logic [1:0] c, input logic [1:0] m, input logic s,
                             input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    cmd = c; mode = m; cs_sel = s; ram_addr = a; wr_data = d;
    @(negedge clk);
    cmd = 2'b00; mode = ~m; cs_sel = ~s; ram_addr = ~a; wr_data = ~d;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 300) begin @(negedge clk); n++; end
    check(nm, busy, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("reset_csn", csn, 2'b11);
    check("reset_sclk", sclk, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_rd_data", rd_data, 8'h00);
    rstn = 1'b1;

    // Write, mode 00, slave 1
    setup_test(1'b0, 1'b0, 8'h00);
    start_frame(2'b10, 2'b00, 1'b1, 7'h55, 8'hA5);
    wait_idle("t1_timeout");
    check("t1_frame", s_last_rx & 32'hFFFF, 16'b0_1010101_10100101);
    check("t1_csn_low", csn01_cnt, 68);
    check("t1_wr_done", wd_cnt, 1);

    // Read, mode 00, slave 0 returns 3C
    setup_test(1'b0, 1'b0, 8'h3C);
    start_frame(2'b01, 2'b00, 1'b0, 7'h12, 8'h99);
    wait_idle("t2_timeout");
    check("t2_rd_data", rd_data, 8'h3C);
    check("t2_rd_done", rd_cnt, 1);
    check("t2_frame", s_last_rx & 32'hFFFF, 16'b1_0010010_00000000);

    // Mode 11 write of FF to address 0
    setup_test(1'b1, 1'b1, 8'h00);
    start_frame(2'b10, 2'b11, 1'b0, 7'h00, 8'hFF);
    wait_idle("t3_timeout");
    check("t3_frame", s_last_rx & 32'hFFFF, 16'b0_0000000_11111111);
    check("t3_pulses", s_last_pulses, 16);
    check("t3_mosi_edges", s_mosi_bad, 0);
    check("t3_sclk_idle", sclk, 1'b1);
    check("t3_rd_kept", rd_data, 8'h3C);

    // Reserved command in idle, command churn while busy
    setup_test(1'b0, 1'b1, 8'h00);
    @(negedge clk); cmd = 2'b11;
    repeat (6) @(negedge clk);
    cmd = 2'b00;
    check("t4_no_busy", busy_cnt, 0);
    check("t4_no_csn", csn_low_cnt, 0);
    @(negedge clk);
    cmd = 2'b10; mode = 2'b01; cs_sel = 1'b1; ram_addr = 7'h0F; wr_data = 8'h5A;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      cmd = 2'(i % 4); mode = 2'(i); cs_sel = 1'(i); ram_addr = 7'(i * 5); wr_data = 8'(i * 7);
    end
    cmd = 2'b00;
    wait_idle("t4_timeout");
    check("t4_frame", s_last_rx & 32'hFFFF, 16'b0_0001111_01011010);
    check("t4_csn_low", csn01_cnt, 68);
    check("t4_wr_done", wd_cnt, 1);
    check("t4_rd_done", rd_cnt, 0);
    check("t4_mosi_edges", s_mosi_bad, 0);

    // Reset during bit 5 of a mode 10 read
    setup_test(1'b1, 1'b0, 8'hC6);
    start_frame(2'b01, 2'b10, 1'b0, 7'h33, 8'h00);
    repeat (23) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check("t5_csn", csn, 2'b11);
    check("t5_sclk", sclk, 1'b0);
    check("t5_busy", busy, 1'b0);
    check("t5_rd_data", rd_data, 8'h00);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    check("t5_no_rd_done", rd_cnt, 0);
    check("t5_rd_data_after", rd_data, 8'h00);

    // Held write command: back-to-back frames
    setup_test(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    cmd = 2'b10; mode = 2'b00; cs_sel = 1'b0; ram_addr = 7'h2A; wr_data = 8'hC3;
    n = 0;
    for (int i = 0; i < 400 && n < 3; i++) begin
      @(negedge clk);
      if (wr_done) n++;
    end
    cmd = 2'b00;
    check("t6_frames_seen", n, 3);
    wait_idle("t6_timeout");
    check("t6_wr_done", wd_cnt, 3);
    check("t6_gap_count", gaps.size(), 2);
    for (int i = 0; i < gaps.size(); i++) check("t6_gap", gaps[i], 2);
    check("t6_frame", s_last_rx & 32'hFFFF, 16'b0_0101010_11000011);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
